// File: rtl/sm_addsub_seq.sv
// Multi-cycle sign-magnitude adder/subtractor: S = A+B and D = A-B with overflow flags.
// Magnitudes are processed CHUNK bits per cycle, LSB chunk first, through a shared chunk slice.

module sm_addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] xa,
    input  logic [CHUNK-1:0] xb,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    input  logic [CHUNK-1:0] xmx,
    input  logic [CHUNK-1:0] xmn,
    input  logic             bin,
    output logic [CHUNK-1:0] dif,
    output logic             bout
);
    logic [CHUNK:0] dt;

    assign {cout, sum} = {1'b0, xa} + {1'b0, xb} + (CHUNK+1)'(cin);
    // A negative chunk difference wraps, leaving the borrow in the top bit.
    assign dt          = {1'b0, xmx} - {1'b0, xmn} - (CHUNK+1)'(bin);
    assign dif         = dt[CHUNK-1:0];
    assign bout        = dt[CHUNK];
endmodule

module sm_addsub_seq #(
    parameter int W     = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W:0]   a,
    input  logic [W:0]   b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   s,
    output logic [W:0]   d,
    output logic         s_ovf,
    output logic         d_ovf
);
    localparam int N  = W / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMP  = 2'd1;
    localparam logic [1:0] ADD  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    if (W % CHUNK != 0) begin : g_bad_chunk
        $error("W must be a multiple of CHUNK");
    end

    logic [1:0]       state;
    logic             sa, sb, a_ge, cy, bw;
    logic [W-1:0]     ma, mb, mx, mn, sum_r, dif_r;
    logic [CW-1:0]    cnt;
    logic             last;

    logic [CHUNK-1:0] c_sum, c_dif;
    logic             c_cout, c_bout;
    logic [W-1:0]     sum_nx, dif_nx;

    logic [W-1:0]     s_mag, d_mag;
    logic             s_sgn, d_sgn, s_c, d_c;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last      = (cnt == CW'(N - 1));

    // Operand registers shift right each ADD cycle so the active chunk is always at bit 0.
    sm_addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .xa   (ma[CHUNK-1:0]),
        .xb   (mb[CHUNK-1:0]),
        .cin  (cy),
        .sum  (c_sum),
        .cout (c_cout),
        .xmx  (mx[CHUNK-1:0]),
        .xmn  (mn[CHUNK-1:0]),
        .bin  (bw),
        .dif  (c_dif),
        .bout (c_bout)
    );

    // Results fill from the top; after N chunks chunk 0 sits at the LSB.
    assign sum_nx = (sum_r >> CHUNK) | (W'(c_sum) << (W - CHUNK));
    assign dif_nx = (dif_r >> CHUNK) | (W'(c_dif) << (W - CHUNK));

    always_comb begin
        s_mag = dif_nx;
        s_sgn = a_ge ? sa : sb;
        s_c   = 1'b0;
        d_mag = sum_nx;
        d_sgn = sa;
        d_c   = c_cout;
        if (sa == sb) begin
            s_mag = sum_nx;
            s_sgn = sa;
            s_c   = c_cout;
            d_mag = dif_nx;
            d_sgn = a_ge ? sa : ~sa;
            d_c   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sa    <= 1'b0;
            sb    <= 1'b0;
            a_ge  <= 1'b0;
            cy    <= 1'b0;
            bw    <= 1'b0;
            ma    <= '0;
            mb    <= '0;
            mx    <= '0;
            mn    <= '0;
            sum_r <= '0;
            dif_r <= '0;
            cnt   <= '0;
            s     <= '0;
            d     <= '0;
            s_ovf <= 1'b0;
            d_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ma    <= a[W-1:0];
                        mb    <= b[W-1:0];
                        // -0 collapses to +0 here so it never steers a result sign.
                        sa    <= a[W] & (|a[W-1:0]);
                        sb    <= b[W] & (|b[W-1:0]);
                        state <= CMP;
                    end
                end
                CMP: begin
                    a_ge  <= (ma >= mb);
                    mx    <= (ma >= mb) ? ma : mb;
                    mn    <= (ma >= mb) ? mb : ma;
                    cy    <= 1'b0;
                    bw    <= 1'b0;
                    cnt   <= '0;
                    state <= ADD;
                end
                ADD: begin
                    ma    <= ma >> CHUNK;
                    mb    <= mb >> CHUNK;
                    mx    <= mx >> CHUNK;
                    mn    <= mn >> CHUNK;
                    sum_r <= sum_nx;
                    dif_r <= dif_nx;
                    cy    <= c_cout;
                    bw    <= c_bout;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        s     <= {s_sgn & (|s_mag), s_mag};
                        d     <= {d_sgn & (|d_mag), d_mag};
                        s_ovf <= s_c;
                        d_ovf <= d_c;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sm_addsub_seq.sv
// Self-checking bench for sm_addsub_seq: directed corner cases, timing, reset abort,
// randomized ops against a signed-integer reference model, and back-to-back streaming.

module tb_sm_addsub_seq;
    localparam int W     = 16;
    localparam int CHUNK = 4;
    localparam int N     = W / CHUNK;
    localparam int LAT   = N + 1;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, out_valid, out_ready, s_ovf, d_ovf;
    logic [W:0]   a, b, s, d;
    int           checks = 0;
    int           errors = 0;

    sm_addsub_seq #(.W(W), .CHUNK(CHUNK)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .d(d), .s_ovf(s_ovf), .d_ovf(d_ovf)
    );

    always #5 clk = ~clk;

    // Reference: convert to signed integers, do real arithmetic, re-encode.
    function automatic void model(input logic [W:0] ia, input logic [W:0] ib,
                                  output logic [W:0] es, output logic [W:0] ed,
                                  output logic eso, output logic edo);
        longint va, vb, vs, vd, ms, md, lim;
        logic [W-1:0] m;
        lim = longint'(1) << W;
        va = longint'(ia[W-1:0]); if (ia[W]) va = -va;
        vb = longint'(ib[W-1:0]); if (ib[W]) vb = -vb;
        vs = va + vb;
        vd = va - vb;
        ms = (vs < 0) ? -vs : vs;
        md = (vd < 0) ? -vd : vd;
        eso = (ms >= lim);
        edo = (md >= lim);
        m  = W'(ms % lim);
        es = {(vs < 0) && (m != 0), m};
        m  = W'(md % lim);
        ed = {(vd < 0) && (m != 0), m};
    endfunction

    function automatic logic [W:0] rnd_op();
        logic [W-1:0] m;
        case ($urandom_range(0, 5))
            0:       m = '0;
            1:       m = '1;
            2:       m = W'($urandom_range(0, 3));
            default: m = W'($urandom);
        endcase
        return {1'($urandom_range(0, 1)), m};
    endfunction

    task automatic run_op(input logic [W:0] ia, input logic [W:0] ib, input int hold,
                          output logic [W:0] os, output logic [W:0] od,
                          output logic oso, output logic odo,
                          output int lat, output bit stable);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
        a = ia; b = ib; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        os = s; od = d; oso = s_ovf; odo = d_ovf; stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (s !== os || d !== od || s_ovf !== oso || d_ovf !== odo || !out_valid || in_ready)
                stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        checks++;
        if (s !== '0 || d !== '0 || s_ovf !== 1'b0 || d_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: s=%h d=%h so=%b do=%b want all 0", s, d, s_ovf, d_ovf);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [W:0] ta [8] = '{17'h00005, 17'h10003, 17'h00003, 17'h00007,
                               17'h10000, 17'h0FFFF, 17'h1FFFF, 17'h10000};
        logic [W:0] tb [8] = '{17'h00003, 17'h00005, 17'h10005, 17'h00007,
                               17'h10000, 17'h00001, 17'h00001, 17'h00005};
        logic [W:0] xs [8] = '{17'h00008, 17'h00002, 17'h10002, 17'h0000E,
                               17'h00000, 17'h00000, 17'h1FFFE, 17'h00005};
        logic [W:0] xd [8] = '{17'h00002, 17'h10008, 17'h00008, 17'h00000,
                               17'h00000, 17'h0FFFE, 17'h00000, 17'h10005};
        logic       xso [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
        logic       xdo [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        logic [W:0] os, od;
        logic       oso, odo;
        int         lat;
        bit         st;
        for (int i = 0; i < 8; i++) begin
            run_op(ta[i], tb[i], 0, os, od, oso, odo, lat, st);
            checks++;
            if (os !== xs[i] || od !== xd[i] || oso !== xso[i] || odo !== xdo[i]) begin
                errors++;
                $display("FAIL directed_%0d: got s=%h d=%h so=%b do=%b want s=%h d=%h so=%b do=%b",
                         i, os, od, oso, odo, xs[i], xd[i], xso[i], xdo[i]);
            end
            checks++;
            if (lat != LAT) begin
                errors++;
                $display("FAIL directed_lat_%0d: got %0d want %0d", i, lat, LAT);
            end
        end
    endtask

    task automatic test_latency_hold();
        logic [W:0] hs, hd;
        a = 17'h00005; b = 17'h00003; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= LAT; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== (c == LAT)) begin
                errors++;
                $display("FAIL lat_edge_%0d: out_valid=%b want %b", c, out_valid, (c == LAT));
            end
        end
        hs = s; hd = d;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (s !== 17'h00008 || d !== 17'h00002 || s !== hs || d !== hd ||
                in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_%0d: s=%h d=%h in_ready=%b out_valid=%b want 00008 00002 0 1",
                         c, s, d, in_ready, out_valid);
            end
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hs_cycle_ready: in_ready=%b want 0", in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_hs: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [W:0] os, od;
        logic       oso, odo;
        int         lat;
        bit         st, seen;
        a = 17'h0FFFF; b = 17'h00001; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || s !== '0 || d !== '0 ||
            s_ovf !== 1'b0 || d_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ov=%b ir=%b s=%h d=%h so=%b do=%b want 0 1 0 0 0 0",
                     out_valid, in_ready, s, d, s_ovf, d_ovf);
        end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_stale: out_valid=1 want 0");
        end
        run_op(17'h00005, 17'h00003, 0, os, od, oso, odo, lat, st);
        checks++;
        if (os !== 17'h00008 || od !== 17'h00002 || lat != LAT) begin
            errors++;
            $display("FAIL reset_mid_next: s=%h d=%h lat=%0d want 00008 00002 %0d", os, od, lat, LAT);
        end
    endtask

    task automatic test_random();
        logic [W:0] ia, ib, os, od, es, ed;
        logic       oso, odo, eso, edo;
        int         lat, hold;
        bit         st;
        for (int i = 0; i < 40; i++) begin
            ia = rnd_op(); ib = rnd_op();
            hold = $urandom_range(0, 3);
            model(ia, ib, es, ed, eso, edo);
            run_op(ia, ib, hold, os, od, oso, odo, lat, st);
            checks++;
            if (os !== es || od !== ed || oso !== eso || odo !== edo || lat != LAT || !st) begin
                errors++;
                $display("FAIL random_%0d: a=%h b=%h got s=%h d=%h so=%b do=%b lat=%0d st=%b want s=%h d=%h so=%b do=%b lat=%0d",
                         i, ia, ib, os, od, oso, odo, lat, st, es, ed, eso, edo, LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] qs[$], qd[$], es, ed;
        logic       qso[$], qdo[$], eso, edo, ex_s, ex_d;
        int         last_acc, ndone, bad_gap;
        bit         acc, overlap, bad_out;
        in_valid = 1'b1; out_ready = 1'b1;
        a = rnd_op(); b = rnd_op();
        last_acc = -1; ndone = 0; bad_gap = 0; overlap = 1'b0; bad_out = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            acc = in_ready;
            if (in_ready && out_valid) overlap = 1'b1;
            if (out_valid) begin
                if (qs.size() == 0) bad_out = 1'b1;
                else begin
                    ex_s = qso.pop_front(); ex_d = qdo.pop_front();
                    es = qs.pop_front(); ed = qd.pop_front();
                    checks++;
                    if (s !== es || d !== ed || s_ovf !== ex_s || d_ovf !== ex_d) begin
                        errors++;
                        $display("FAIL b2b_%0d: got s=%h d=%h so=%b do=%b want s=%h d=%h so=%b do=%b",
                                 ndone, s, d, s_ovf, d_ovf, es, ed, ex_s, ex_d);
                    end
                end
                ndone++;
            end
            @(posedge clk); #1;
            if (acc) begin
                model(a, b, es, ed, eso, edo);
                qs.push_back(es); qd.push_back(ed); qso.push_back(eso); qdo.push_back(edo);
                if (last_acc >= 0 && cyc - last_acc != LAT + 2) bad_gap++;
                last_acc = cyc;
                a = rnd_op(); b = rnd_op();
            end
        end
        in_valid = 1'b0;
        checks++;
        if (overlap || bad_out || bad_gap != 0 || ndone < 7) begin
            errors++;
            $display("FAIL b2b_flow: overlap=%b stray=%b bad_gaps=%0d done=%0d want 0 0 0 >=7",
                     overlap, bad_out, bad_gap, ndone);
        end
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_latency_hold();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
